ps2_kbmat: RTL



---
 rtl/ps2_kbmat.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbmat.sv
// PS/2 keyboard receiver and Z88 key matrix builder.
// Conditions the raw pins, frames bytes, and decodes set-2 scan codes into a 64-bit matrix.
module ps2_kbmat #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 19660
) (
  input  logic        mck,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        rx_err
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;

  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          strobe, dat;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic [63:0]   kbmat_q, kbmat_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic          map_hit;
  logic [5:0]    map_idx;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    filt_d     = filt_q;
    fcnt_d     = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = clk_sync_q[1];
      else                             fcnt_d = fcnt_q + FW'(1);
    end
    strobe = filt_q & ~filt_d;
    dat    = dat_sync_q[1];
  end

  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_ff @(posedge mck or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    to_d       = (strobe || state_q == IDLE) ? '0 : to_q + TW'(1);
    if (strobe) begin
      case (state_q)
        IDLE: if (!dat) begin
          state_d = DATA;
          bcnt_d  = 3'd0;
          shift_d = 8'h00;
        end
        DATA: begin
          shift_d = {dat, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, dat};
          state_d  = STOP;
        end
        default: begin
          if (dat && par_ok_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE && to_q == TW'(TIMEOUT - 1)) begin
      // stalled frame: abandon it, the partial byte never reaches rx_byte
      rx_err_d = 1'b1;
      state_d  = IDLE;
    end
  end

  // Z88 matrix position for each set-2 code; upper bit of the selector is the E0 prefix
  always_comb begin
    map_hit = 1'b1;
    map_idx = 6'd0;
    case ({ext_q, rx_byte_q})
      9'h066: map_idx = 6'd7;   9'h05A: map_idx = 6'd6;   9'h036: map_idx = 6'd5;   9'h035: map_idx = 6'd4;
      9'h175: map_idx = 6'd3;   9'h172: map_idx = 6'd2;   9'h03D: map_idx = 6'd1;   9'h03E: map_idx = 6'd0;
      9'h05D: map_idx = 6'd15;  9'h033: map_idx = 6'd14;  9'h02E: map_idx = 6'd13;  9'h02C: map_idx = 6'd12;
      9'h034: map_idx = 6'd11;  9'h032: map_idx = 6'd10;  9'h03C: map_idx = 6'd9;   9'h043: map_idx = 6'd8;
      9'h055: map_idx = 6'd23;  9'h031: map_idx = 6'd22;  9'h025: map_idx = 6'd21;  9'h02D: map_idx = 6'd20;
      9'h02B: map_idx = 6'd19;  9'h02A: map_idx = 6'd18;  9'h03B: map_idx = 6'd17;  9'h044: map_idx = 6'd16;
      9'h04E: map_idx = 6'd31;  9'h174: map_idx = 6'd30;  9'h026: map_idx = 6'd29;  9'h024: map_idx = 6'd28;
      9'h023: map_idx = 6'd27;  9'h021: map_idx = 6'd26;  9'h042: map_idx = 6'd25;  9'h046: map_idx = 6'd24;
      9'h05B: map_idx = 6'd39;  9'h16B: map_idx = 6'd38;  9'h01C: map_idx = 6'd37;  9'h01D: map_idx = 6'd36;
      9'h01B: map_idx = 6'd35;  9'h022: map_idx = 6'd34;  9'h03A: map_idx = 6'd33;  9'h04D: map_idx = 6'd32;
      9'h054: map_idx = 6'd47;  9'h029: map_idx = 6'd46;  9'h016: map_idx = 6'd45;  9'h015: map_idx = 6'd44;
      9'h01E: map_idx = 6'd43;  9'h01A: map_idx = 6'd42;  9'h04B: map_idx = 6'd41;  9'h045: map_idx = 6'd40;
      9'h004: map_idx = 6'd55;  9'h012: map_idx = 6'd54;  9'h00D: map_idx = 6'd53;  9'h014: map_idx = 6'd52;
      9'h006: map_idx = 6'd51;  9'h041: map_idx = 6'd50;  9'h04C: map_idx = 6'd49;  9'h052: map_idx = 6'd48;
      9'h059: map_idx = 6'd63;  9'h011: map_idx = 6'd62;  9'h076: map_idx = 6'd61;  9'h005: map_idx = 6'd60;
      9'h058: map_idx = 6'd59;  9'h049: map_idx = 6'd58;  9'h04A: map_idx = 6'd57;  9'h00E: map_idx = 6'd56;
      9'h15A: map_idx = 6'd6;   9'h114: map_idx = 6'd52;
      default: map_hit = 1'b0;
    endcase
  end

  always_comb begin
    kbmat_d = kbmat_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    if (rx_valid_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (rx_byte_q)
          8'hE1: skip_d = 3'd7;
          8'hE0: ext_d  = 1'b1;
          8'hF0: brk_d  = 1'b1;
          8'hAA, 8'hFC, 8'h00, 8'hFF: begin
            kbmat_d = '0;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
          default: begin
            if (map_hit) kbmat_d[map_idx] = ~brk_q;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge mck or posedge rst) begin
    if (rst) begin
      bcnt_q     <= 3'd0;
      shift_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      to_q       <= '0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      kbmat_q    <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= 3'd0;
    end else begin
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      to_q       <= to_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      kbmat_q    <= kbmat_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
    end
  end

  assign kbmat    = kbmat_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
endmodule
